// File: rtl/turn_signal_conditioner.sv
// Conditions raw left/right/hazard switches into consistent left/right requests
// for the tail-light sequencer: sync, debounce per channel, then arbitrate.

module tsc_debounce #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic db
);
    logic [1:0]       sync;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync <= '0;
            cnt  <= '0;
            db   <= 1'b0;
        end else begin
            sync <= {sync[0], raw};
            if (sync[1] == db) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                db  <= sync[1];
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module turn_signal_conditioner #(
    parameter  int DEBOUNCE_CYCLES = 4,
    localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic left_raw,
    input  logic right_raw,
    input  logic hazard_raw,
    output logic left,
    output logic right,
    output logic change
);
    localparam int NUM_LANES = 3;
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LEFT   = 2'd1;
    localparam logic [1:0] S_RIGHT  = 2'd2;
    localparam logic [1:0] S_HAZARD = 2'd3;

    logic [NUM_LANES-1:0] raw_vec;
    logic [NUM_LANES-1:0] db;
    logic [1:0]           state, state_n;
    logic                 left_n, right_n;

    assign raw_vec = {hazard_raw, right_raw, left_raw};

    // lane 0 = left, 1 = right, 2 = hazard
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        tsc_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_db (
            .clk  (clk),
            .reset(reset),
            .raw  (raw_vec[i]),
            .db   (db[i])
        );
    end

    always_comb begin
        state_n = state;
        if (db[2]) begin
            state_n = S_HAZARD;
        end else begin
            case (state)
                S_IDLE: begin
                    if (db[0] && db[1]) state_n = S_HAZARD;
                    else if (db[0])     state_n = S_LEFT;
                    else if (db[1])     state_n = S_RIGHT;
                    else                state_n = S_IDLE;
                end
                // first request wins; the other side waits for a pass through IDLE
                S_LEFT:   state_n = db[0] ? S_LEFT : S_IDLE;
                S_RIGHT:  state_n = db[1] ? S_RIGHT : S_IDLE;
                default:  state_n = (db[0] && db[1]) ? S_HAZARD : S_IDLE;
            endcase
        end
    end

    assign left_n  = (state_n == S_LEFT)  || (state_n == S_HAZARD);
    assign right_n = (state_n == S_RIGHT) || (state_n == S_HAZARD);

    // outputs registered alongside the state so change lands in the same cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= S_IDLE;
            left   <= 1'b0;
            right  <= 1'b0;
            change <= 1'b0;
        end else begin
            state  <= state_n;
            left   <= left_n;
            right  <= right_n;
            change <= ({left_n, right_n} != {left, right});
        end
    end
endmodule
